// File: rtl/wb_sched.sv
// Writeback scheduler: muxes PC+4/ALU/load data onto the register-file write port,
// stalls the core across variable-latency loads and arbitrates a debug writer.
// Optional macro LOAD_TIMEOUT_EN adds a load wait limit (TIMEOUT_CYCLES) with o_ld_err.
module wb_sched #(
  parameter int DBG_MAX_WAIT   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_en,
  input  logic [1:0]  i_wb_sel,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_pc_four,
  input  logic [31:0] i_alu_data,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  input  logic [31:0] i_ld_data,
  output logic        o_stall,
  input  logic        i_dbg_req,
  input  logic [4:0]  i_dbg_addr,
  input  logic [31:0] i_dbg_data,
  output logic        o_dbg_gnt,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_ld_err
);

  // state   | meaning
  // IDLE    | core writes pass through; a load issues here
  // LD_WAIT | load outstanding, core stalled until ack (or timeout)
  typedef enum logic {IDLE, LD_WAIT} state_t;

  localparam int DW = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [DW-1:0] DBG_MAX = DW'(DBG_MAX_WAIT);

  state_t        state, state_nxt;
  logic [4:0]    ld_rd, ld_rd_nxt;
  logic [DW-1:0] dbg_cnt, dbg_cnt_nxt;
  logic          timeout;
  logic          forced;

  logic          wren_c, stall_c, req_c, gnt_c, err_c;
  logic [4:0]    addr_c;
  logic [31:0]   data_c;

`ifdef LOAD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;

  // Counts completed LD_WAIT cycles; the cycle seeing TO_LAST is the last one allowed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      to_cnt <= '0;
    else if (state == LD_WAIT && state_nxt == LD_WAIT)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end

  assign timeout = (state == LD_WAIT) && (to_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      ld_rd   <= '0;
      dbg_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ld_rd   <= ld_rd_nxt;
      dbg_cnt <= dbg_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_rd_nxt = ld_rd;
    wren_c    = 1'b0;
    addr_c    = '0;
    data_c    = '0;
    stall_c   = 1'b0;
    req_c     = 1'b0;
    gnt_c     = 1'b0;
    err_c     = 1'b0;
    forced    = (state == IDLE) && i_dbg_req && (dbg_cnt == DBG_MAX);

    case (state)
      IDLE: begin
        if (forced) begin
          // Starved debug writer takes the port; the core holds and retries.
          gnt_c   = 1'b1;
          wren_c  = 1'b1;
          addr_c  = i_dbg_addr;
          data_c  = i_dbg_data;
          stall_c = 1'b1;
        end else if (i_wb_en && i_wb_sel == 2'b10) begin
          req_c     = 1'b1;
          stall_c   = 1'b1;
          ld_rd_nxt = i_rd_addr;
          state_nxt = LD_WAIT;
        end else if (i_wb_en) begin
          wren_c = 1'b1;
          addr_c = i_rd_addr;
          case (i_wb_sel)
            2'b00:   data_c = i_pc_four;
            2'b01:   data_c = i_alu_data;
            default: data_c = '0;
          endcase
        end else if (i_dbg_req) begin
          gnt_c  = 1'b1;
          wren_c = 1'b1;
          addr_c = i_dbg_addr;
          data_c = i_dbg_data;
        end
      end
      LD_WAIT: begin
        if (i_mem_ack) begin
          wren_c    = 1'b1;
          addr_c    = ld_rd;
          data_c    = i_ld_data;
          state_nxt = IDLE;
        end else begin
          if (timeout) begin
            err_c     = 1'b1;
            state_nxt = IDLE;
          end else begin
            req_c   = 1'b1;
            stall_c = 1'b1;
          end
          if (i_dbg_req) begin
            gnt_c  = 1'b1;
            wren_c = 1'b1;
            addr_c = i_dbg_addr;
            data_c = i_dbg_data;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (addr_c == 5'd0)
      wren_c = 1'b0;
  end

  always_comb begin
    dbg_cnt_nxt = dbg_cnt;
    if (!i_dbg_req || gnt_c)
      dbg_cnt_nxt = '0;
    else if (dbg_cnt != DBG_MAX)
      dbg_cnt_nxt = dbg_cnt + 1'b1;
  end

  // Outputs are combinational from inputs, so gate them directly with the reset pin.
  assign o_rd_wren = wren_c  & i_rst_n;
  assign o_rd_addr = addr_c  & {5{i_rst_n}};
  assign o_rd_data = data_c  & {32{i_rst_n}};
  assign o_stall   = stall_c & i_rst_n;
  assign o_mem_req = req_c   & i_rst_n;
  assign o_dbg_gnt = gnt_c   & i_rst_n;
  assign o_ld_err  = err_c   & i_rst_n;

endmodule

// File: tb/tb_wb_sched.sv
// Scoreboard bench for wb_sched: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_wb_sched;

  localparam logic [31:0] PC4 = 32'h0000_0104;
  localparam logic [31:0] ALU = 32'h0000_1234;
  localparam logic [31:0] LDD = 32'hDEAD_BEEF;
  localparam logic [31:0] DBG = 32'hCAFE_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_addr;
  logic        mem_req, mem_ack, stall;
  logic        dbg_req, dbg_gnt;
  logic [4:0]  dbg_addr;
  logic        rd_wren, ld_err;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  wb_sched dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_sel(wb_sel),
    .i_rd_addr(rd_addr), .i_pc_four(PC4), .i_alu_data(ALU),
    .o_mem_req(mem_req), .i_mem_ack(mem_ack), .i_ld_data(LDD),
    .o_stall(stall), .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr),
    .i_dbg_data(DBG), .o_dbg_gnt(dbg_gnt), .o_rd_wren(rd_wren),
    .o_rd_addr(rd_addr_o), .o_rd_data(rd_data), .o_ld_err(ld_err)
  );

  typedef struct {
    int          idx;
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall, req, gnt, err;
  } exp_t;

  exp_t q[$];
  int   n_step = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic step(input logic r, input logic en, input logic [1:0] sel,
                      input logic [4:0] rd, input logic ack, input logic dr,
                      input logic [4:0] da, input logic ew, input logic [4:0] ea,
                      input logic [31:0] ed, input logic es, input logic eq,
                      input logic eg, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; wb_en = en; wb_sel = sel; rd_addr = rd;
    mem_ack = ack; dbg_req = dr; dbg_addr = da;
    e.idx = n_step; e.wren = ew; e.addr = ea; e.data = ed;
    e.stall = es; e.req = eq; e.gnt = eg; e.err = ee;
    q.push_back(e);
    n_step++;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (rd_wren !== e.wren || stall !== e.stall || mem_req !== e.req ||
          dbg_gnt !== e.gnt || ld_err !== e.err ||
          (e.wren && (rd_addr_o !== e.addr || rd_data !== e.data))) begin
        errors++;
        $display("FAIL step%0d: got wren=%b addr=%0d data=%h stall=%b req=%b gnt=%b err=%b, expected wren=%b addr=%0d data=%h stall=%b req=%b gnt=%b err=%b",
                 e.idx, rd_wren, rd_addr_o, rd_data, stall, mem_req, dbg_gnt, ld_err,
                 e.wren, e.addr, e.data, e.stall, e.req, e.gnt, e.err);
      end
    end
  end

  initial begin
    rst_n = 1'b0; wb_en = 1'b0; wb_sel = 2'b00; rd_addr = '0;
    mem_ack = 1'b0; dbg_req = 1'b0; dbg_addr = '0;

    // reset: outputs forced low even with an active ALU write on the inputs
    step(0, 1, 2'b01, 5'd5, 0, 0, 5'd0,   0, 5'd0, 32'h0, 0, 0, 0, 0);
    // core writes: ALU, PC+4, zero, ALU to x0
    step(1, 1, 2'b01, 5'd5, 0, 0, 5'd0,   1, 5'd5,  ALU,   0, 0, 0, 0);
    step(1, 1, 2'b00, 5'd9, 0, 0, 5'd0,   1, 5'd9,  PC4,   0, 0, 0, 0);
    step(1, 1, 2'b11, 5'd10, 0, 0, 5'd0,  1, 5'd10, 32'h0, 0, 0, 0, 0);
    step(1, 1, 2'b01, 5'd0, 0, 0, 5'd0,   0, 5'd0, 32'h0, 0, 0, 0, 0);
    // opportunistic debug write with idle core
    step(1, 0, 2'b00, 5'd0, 0, 1, 5'd3,   1, 5'd3,  DBG,   0, 0, 1, 0);
    // load rd=7, ack three cycles after issue; wb inputs ignored while waiting
    step(1, 1, 2'b10, 5'd7, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(1, 1, 2'b01, 5'd5, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(1, 1, 2'b01, 5'd5, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(1, 1, 2'b10, 5'd5, 1, 0, 5'd0,   1, 5'd7,  LDD,   0, 0, 0, 0);
    step(1, 0, 2'b00, 5'd0, 0, 0, 5'd0,   0, 5'd0, 32'h0, 0, 0, 0, 0);
    // starvation: four core writes, then forced grant on the 5th request cycle
    for (int i = 0; i < 4; i++)
      step(1, 1, 2'b01, 5'd5, 0, 1, 5'd4, 1, 5'd5, ALU,    0, 0, 0, 0);
    step(1, 1, 2'b01, 5'd5, 0, 1, 5'd4,   1, 5'd4,  DBG,   1, 0, 1, 0);
    step(1, 1, 2'b01, 5'd5, 0, 0, 5'd0,   1, 5'd5,  ALU,   0, 0, 0, 0);
    // forced grant suppresses a load issue: no mem_req, core retries
    for (int i = 0; i < 4; i++)
      step(1, 1, 2'b01, 5'd5, 0, 1, 5'd4, 1, 5'd5, ALU,    0, 0, 0, 0);
    step(1, 1, 2'b10, 5'd8, 0, 1, 5'd4,   1, 5'd4,  DBG,   1, 0, 1, 0);
    // debug during LD_WAIT, then load rd=8 completes; ack beats pending debug
    step(1, 1, 2'b10, 5'd8, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(1, 0, 2'b00, 5'd0, 0, 1, 5'd3,   1, 5'd3,  DBG,   1, 1, 1, 0);
    step(1, 0, 2'b00, 5'd0, 1, 1, 5'd3,   1, 5'd8,  LDD,   0, 0, 0, 0);
    step(1, 0, 2'b00, 5'd0, 0, 1, 5'd3,   1, 5'd3,  DBG,   0, 0, 1, 0);
    // load to x0: request and stall, but no write
    step(1, 1, 2'b10, 5'd0, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(1, 0, 2'b00, 5'd0, 1, 0, 5'd0,   0, 5'd0, 32'h0, 0, 0, 0, 0);
    // debug to x0 granted without write; stray ack in IDLE ignored
    step(1, 0, 2'b00, 5'd0, 0, 1, 5'd0,   0, 5'd0, 32'h0, 0, 0, 1, 0);
    step(1, 0, 2'b00, 5'd0, 1, 0, 5'd0,   0, 5'd0, 32'h0, 0, 0, 0, 0);
    // reset asserted mid LD_WAIT with ack present: nothing written, IDLE after
    step(1, 1, 2'b10, 5'd7, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(1, 0, 2'b00, 5'd0, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(0, 0, 2'b00, 5'd0, 1, 0, 5'd0,   0, 5'd0, 32'h0, 0, 0, 0, 0);
    step(1, 0, 2'b00, 5'd0, 1, 0, 5'd0,   0, 5'd0, 32'h0, 0, 0, 0, 0);
    step(1, 1, 2'b01, 5'd6, 0, 0, 5'd0,   1, 5'd6,  ALU,   0, 0, 0, 0);
`ifdef LOAD_TIMEOUT_EN
    // no ack: error pulse on the 16th LD_WAIT cycle, stall released, no write
    step(1, 1, 2'b10, 5'd7, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    for (int i = 0; i < 15; i++)
      step(1, 0, 2'b00, 5'd0, 0, 0, 5'd0, 0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(1, 0, 2'b00, 5'd0, 0, 0, 5'd0,   0, 5'd0, 32'h0, 0, 0, 0, 1);
    step(1, 1, 2'b01, 5'd6, 0, 0, 5'd0,   1, 5'd6,  ALU,   0, 0, 0, 0);
`else
    // without the timeout option a long wait never errors
    step(1, 1, 2'b10, 5'd7, 0, 0, 5'd0,   0, 5'd0, 32'h0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++)
      step(1, 0, 2'b00, 5'd0, 0, 0, 5'd0, 0, 5'd0, 32'h0, 1, 1, 0, 0);
    step(1, 0, 2'b00, 5'd0, 1, 0, 5'd0,   1, 5'd7,  LDD,   0, 0, 0, 0);
`endif

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_sched.md
# wb_sched

Writeback scheduler for the single-cycle core's register-file write port. It selects the writeback source (PC+4, ALU result or load data), stalls the core while a variable-latency load is outstanding, and shares the same write port with a debug requester. It sits between the core datapath, the data-memory response and the register file.

## Interface
Parameters:
- DBG_MAX_WAIT, default 4: cycles a pending debug write may wait before it is forced in.
- TIMEOUT_CYCLES, default 16: load wait limit, used only with LOAD_TIMEOUT_EN.

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wb_en  in  1  current instruction writes rd.
- i_wb_sel  in  2  00 pc_four, 01 alu, 10 load, 11 zero.
- i_rd_addr  in  5  destination register.
- i_pc_four  in  32  PC+4.
- i_alu_data  in  32  ALU result.
- o_mem_req  out  1  load request to data memory.
- i_mem_ack  in  1  load data valid.
- i_ld_data  in  32  load data.
- o_stall  out  1  hold PC and instruction.
- i_dbg_req  in  1  debug write request.
- i_dbg_addr  in  5  debug destination register.
- i_dbg_data  in  32  debug write data.
- o_dbg_gnt  out  1  debug write accepted this cycle.
- o_rd_wren  out  1  register-file write enable.
- o_rd_addr  out  5  register-file write address.
- o_rd_data  out  32  register-file write data.
- o_ld_err  out  1  load timeout pulse. Tied 0 without LOAD_TIMEOUT_EN.

## Operation
- FSM has two states: IDLE and LD_WAIT.
- Registered state: FSM state, latched load rd (5 bits), debug wait counter, timeout counter.
- IDLE, core write (i_wb_en=1, i_wb_sel≠10):
  - Write occurs in the same cycle; o_rd_wren=1.
  - Data is i_pc_four, i_alu_data or 32'h0 for sel 00/01/11.
- IDLE, load (i_wb_en=1, i_wb_sel=10):
  - Assert o_mem_req and o_stall.
  - Latch i_rd_addr and go to LD_WAIT. No write this cycle.
- LD_WAIT:
  - o_mem_req=1 and o_stall=1 until i_mem_ack.
  - Ack cycle: o_rd_wren=1, o_rd_addr=latched rd, o_rd_data=i_ld_data, o_stall=0, o_mem_req=0; next state IDLE.
  - The core commits the load at that edge.
  - i_wb_* inputs are ignored in LD_WAIT.
- Debug arbitration:
  - i_dbg_req is granted in any cycle where the port is free: IDLE with i_wb_en=0, or LD_WAIT without ack.
  - Debug write uses i_dbg_addr / i_dbg_data.
  - The wait counter increments each cycle i_dbg_req=1 and is not granted.
  - The counter clears on grant or when the request drops.
  - Counter==DBG_MAX_WAIT in IDLE: force the grant.
    - Assert o_stall.
    - Suppress the core write or load issue. The core retries next cycle.
    - o_mem_req stays 0.
  - The forced grant never preempts a load ack.
- x0 rule: any write with address 0 has o_rd_wren=0. A load to x0 still requests memory and stalls. A debug write to x0 is still granted.
- i_mem_ack outside LD_WAIT is ignored.

## Timing
- Reset (async assert):
  - State IDLE; counters and latched rd are 0.
  - All outputs 0 while i_rst_n=0.
  - Reset during LD_WAIT drops o_mem_req and writes nothing.
- Reset deassertion is synchronized externally. The first active edge starts in IDLE.
- ALU and PC writebacks: 0-cycle latency (combinational from inputs and state).
- Load: stall for 1 issue cycle + N wait cycles, where N≥0 is the ack delay after LD_WAIT entry. The write occurs in the ack cycle.
- Minimum load: 2 cycles (issue, then ack in the first LD_WAIT cycle).
- At most one writer per cycle. Priority: load ack > forced debug > core > opportunistic debug.

## Configuration
- LOAD_TIMEOUT_EN defined:
  - The timeout counter counts LD_WAIT cycles.
  - When it reaches TIMEOUT_CYCLES with no ack: o_ld_err=1 for one cycle, no write, o_stall=0, o_mem_req=0, return to IDLE.
  - An ack in the same cycle as the timeout wins: normal write, no error.
- LOAD_TIMEOUT_EN undefined: LD_WAIT waits indefinitely; o_ld_err is constant 0; no counter logic.

## Test plan
- ALU write: wb_sel=01, rd=5, alu=32'h1234 -> same cycle o_rd_wren=1, addr 5, data 32'h1234, o_stall=0.
- Load with ack 3 cycles after issue, rd=7, ld_data=32'hDEADBEEF:
  - o_stall high for 3 cycles, o_mem_req held.
  - Write of 32'hDEADBEEF to rd 7 in the ack cycle.
- Debug starvation: continuous core ALU writes plus i_dbg_req -> forced grant on the 5th request cycle (DBG_MAX_WAIT=4), with o_stall=1 and no core write that cycle.
- Debug during LD_WAIT: dbg_req with addr 3 while a load waits -> granted immediately; the load completes afterwards correctly.
- x0 and reset:
  - Load to x0 -> memory request and stall, but o_rd_wren stays 0.
  - Assert i_rst_n=0 mid-LD_WAIT -> all outputs 0 immediately, IDLE after release.
- LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> o_ld_err pulse on the 16th LD_WAIT cycle, no write, stall released.
